log_map: RTL
============

LOG_MAP -- requirements
Module: log_map

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of the normalized mantissa input.
REQ-002 SHALL have parameter SHIFT_WIDTH, default $clog2(DATA_WIDTH): width of the leading-zero shift input.
REQ-003 SHALL have parameter FRAC_BITS, default 4: fractional bits of the log2 value.
REQ-004 SHALL have parameter PIX_WIDTH, default 8: output pixel width.
REQ-005 SHALL have parameter GAIN, default 3: unsigned dynamic-range multiplier.
REQ-006 SHALL have parameter GAIN_SHIFT, default 1: right shift applied after the multiply.
REQ-007 SHALL have parameter OFFSET, default 64: value subtracted after scaling.
REQ-008 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-009 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-010 SHALL have port in_valid, input, 1 bit: upstream sample valid.
REQ-011 SHALL have port in_ready, output, 1 bit: this block accepts a sample.
REQ-012 SHALL have port data_in, input, DATA_WIDTH bits: normalized mantissa, MSB expected to be 1.
REQ-013 SHALL have port shift_in, input, SHIFT_WIDTH bits: left-shift count the upstream stage used for normalization.
REQ-014 SHALL have port out_valid, output, 1 bit: pix_out holds a valid pixel.
REQ-015 SHALL have port out_ready, input, 1 bit: downstream accepts the pixel.
REQ-016 SHALL have port pix_out, output, PIX_WIDTH bits: log-compressed pixel.
REQ-017 SHALL have port clip_hi, output, 1 bit: pix_out was clamped to the maximum; qualified by out_valid.
REQ-018 SHALL have port clip_lo, output, 1 bit: pix_out was clamped to 0; qualified by out_valid.
REQ-019 SHALL have port clr_count, input, 1 bit: synchronous clear of clip_count.
REQ-020 SHALL have port clip_count, output, 16 bits: count of clipped pixels transferred downstream.

Function
REQ-021 SHALL be a 3-stage pipeline: S1 computes log2, S2 scales, S3 clamps into the output registers; each stage has its own valid bit.
REQ-022 SHALL use a global advance enable adv = !out_valid || out_ready, and SHALL drive in_ready = adv combinationally.
REQ-023 When adv=1, all stages SHALL shift one position, and S1 SHALL load in_valid && in_ready. When adv=0, all stage registers SHALL hold.
REQ-024 SHALL accept one sample per cycle when out_ready is held 1; latency from the accepting edge to out_valid SHALL be 3 cycles.
REQ-025 S1 SHALL compute the integer part I = (DATA_WIDTH-1) - shift_in; if shift_in > DATA_WIDTH-1, I SHALL be 0.
REQ-026 S1 SHALL compute the fraction F = data_in[DATA_WIDTH-2 -: FRAC_BITS] (Mitchell linear approximation), and L = {I, F}, unsigned, SHIFT_WIDTH+FRAC_BITS bits.
REQ-027 If data_in MSB is 0 (input not normalized), S1 SHALL force L = 0.
REQ-028 S2 SHALL compute the signed value V = ((L * GAIN) >> GAIN_SHIFT) - OFFSET, sized so that no overflow or truncation occurs before the clamp.
REQ-029 S3 SHALL output pix_out = 0 with clip_lo=1 if V < 0; pix_out = 2^PIX_WIDTH-1 with clip_hi=1 if V > 2^PIX_WIDTH-1; otherwise pix_out = V[PIX_WIDTH-1:0] with both flags 0.
REQ-030 pix_out, clip_hi and clip_lo SHALL remain stable while out_valid=1 and out_ready=0.
REQ-031 clip_count SHALL increment by 1 on each cycle where out_valid && out_ready && (clip_hi || clip_lo).
REQ-032 clip_count SHALL saturate at 0xFFFF.
REQ-033 clr_count SHALL set clip_count to 0 on the next edge; clr_count SHALL win over a simultaneous increment, so that transfer is not counted.
REQ-034 A bubble (stage valid=0) SHALL propagate without affecting clip_count or the output flags' qualification.

Reset
REQ-035 While reset=1 on a rising edge, SHALL clear all stage valid bits, out_valid, pix_out, clip_hi, clip_lo and clip_count to 0.
REQ-036 Reset mid-operation SHALL discard all in-flight samples; no partially processed pixel SHALL appear afterward.
REQ-037 in_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-038 data_in=0xC000, shift_in=7, out_ready=1 -> 3 cycles later out_valid=1, pix_out=140 (L=136), clip_hi=0, clip_lo=0.
REQ-039 data_in=0x8000, shift_in=15 -> L=0, V=-64, pix_out=0, clip_lo=1; data_in=0x8000, shift_in=0 -> V=296, pix_out=255, clip_hi=1; clip_count=2 after both transfers.
REQ-040 Back-to-back stream of 8 samples with out_ready=0 for 4 mid-stream cycles -> no sample lost or duplicated, order preserved, pix_out stable during the stall, in_ready=0 while the output is stalled.
REQ-041 data_in=0x4000 (MSB 0), any shift_in -> pix_out=0, clip_lo=1.
REQ-042 clip_count forced near 0xFFFF by 70000 clipped transfers -> clip_count holds 0xFFFF; clr_count asserted together with a clipped transfer -> clip_count=0.
REQ-043 reset asserted with 3 samples in flight -> out_valid=0 the next cycle, clip_count=0, and no stale pixel appears after release.

Source files
------------

// File: rtl/log_map.sv
// log_map: 3-stage log2 (Mitchell) compression with gain/offset, clamp and clip counter
module log_map #(
   parameter int DATA_WIDTH  = 16,
   parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH),
   parameter int FRAC_BITS   = 4,
   parameter int PIX_WIDTH   = 8,
   parameter int GAIN        = 3,
   parameter int GAIN_SHIFT  = 1,
   parameter int OFFSET      = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_WIDTH-1:0]  data_in,
   input  logic [SHIFT_WIDTH-1:0] shift_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [PIX_WIDTH-1:0]   pix_out,
   output logic                   clip_hi,
   output logic                   clip_lo,
   input  logic                   clr_count,
   output logic [15:0]            clip_count
);
   localparam int LW = SHIFT_WIDTH + FRAC_BITS;
   localparam int MW = LW + $clog2(GAIN + 1);
   localparam int OW = $clog2(OFFSET + 1);
   localparam int AW = (MW > OW) ? MW : OW;
   localparam int VW = ((AW > PIX_WIDTH) ? AW : PIX_WIDTH) + 2;
   localparam logic signed [VW-1:0] PIX_MAX = VW'(2 ** PIX_WIDTH - 1);

   logic                   adv;
   logic [SHIFT_WIDTH-1:0] i_part;
   logic [LW-1:0]          l_new;
   logic [MW-1:0]          prod;
   logic signed [VW-1:0]   v_new;
   logic                   lo_new, hi_new;
   logic [PIX_WIDTH-1:0]   pix_new;
   logic                   unused_bits;

   logic                   s1_valid_q, s1_valid_d;
   logic [LW-1:0]          s1_l_q, s1_l_d;
   logic                   s2_valid_q, s2_valid_d;
   logic signed [VW-1:0]   s2_v_q, s2_v_d;
   logic                   out_valid_q, out_valid_d;
   logic [PIX_WIDTH-1:0]   pix_out_q, pix_out_d;
   logic                   clip_hi_q, clip_hi_d;
   logic                   clip_lo_q, clip_lo_d;
   logic [15:0]            clip_count_q, clip_count_d;

   assign unused_bits = ^data_in[DATA_WIDTH-FRAC_BITS-2:0];
   assign in_ready    = adv;
   assign out_valid   = out_valid_q;
   assign pix_out     = pix_out_q;
   assign clip_hi     = clip_hi_q;
   assign clip_lo     = clip_lo_q;
   assign clip_count  = clip_count_q;

   always_comb begin
      adv          = !out_valid_q || out_ready;
      i_part       = (int'(shift_in) > DATA_WIDTH - 1) ? '0 : SHIFT_WIDTH'(DATA_WIDTH - 1 - int'(shift_in));
      l_new        = data_in[DATA_WIDTH-1] ? {i_part, data_in[DATA_WIDTH-2 -: FRAC_BITS]} : '0;
      prod         = MW'(s1_l_q) * MW'(GAIN);
      v_new        = $signed(VW'(prod >> GAIN_SHIFT)) - $signed(VW'(OFFSET));
      lo_new       = s2_v_q < 0;
      hi_new       = s2_v_q > PIX_MAX;
      pix_new      = lo_new ? '0 : hi_new ? '1 : s2_v_q[PIX_WIDTH-1:0];
      s1_valid_d   = adv ? in_valid : s1_valid_q;
      s1_l_d       = adv ? l_new : s1_l_q;
      s2_valid_d   = adv ? s1_valid_q : s2_valid_q;
      s2_v_d       = adv ? v_new : s2_v_q;
      out_valid_d  = adv ? s2_valid_q : out_valid_q;
      pix_out_d    = adv ? pix_new : pix_out_q;
      clip_hi_d    = adv ? hi_new : clip_hi_q;
      clip_lo_d    = adv ? lo_new : clip_lo_q;
      clip_count_d = clr_count ? '0 :
                     (out_valid_q && out_ready && (clip_hi_q || clip_lo_q) && clip_count_q != 16'hFFFF) ?
                     clip_count_q + 16'd1 : clip_count_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q   <= 1'b0;
         s1_l_q       <= '0;
         s2_valid_q   <= 1'b0;
         s2_v_q       <= '0;
         out_valid_q  <= 1'b0;
         pix_out_q    <= '0;
         clip_hi_q    <= 1'b0;
         clip_lo_q    <= 1'b0;
         clip_count_q <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_l_q       <= s1_l_d;
         s2_valid_q   <= s2_valid_d;
         s2_v_q       <= s2_v_d;
         out_valid_q  <= out_valid_d;
         pix_out_q    <= pix_out_d;
         clip_hi_q    <= clip_hi_d;
         clip_lo_q    <= clip_lo_d;
         clip_count_q <= clip_count_d;
      end
   end
endmodule
